// File: rtl/imem_pipe.sv
// imem_pipe: word-organised instruction memory with preload port and a LATENCY-stage valid/ready read pipe.
// Define IMEM_TRACE_EN to print a trace line for every completed response.
module imem_pipe #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [31:0]       rsp_addr,
  output logic              rsp_err,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [31:0]       fetch_cnt
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [LATENCY-1:0] v_q, v_d, e_q, e_d;
  logic [DATA_W-1:0] d_q [LATENCY];
  logic [DATA_W-1:0] d_d [LATENCY];
  logic [31:0] a_q [LATENCY];
  logic [31:0] a_d [LATENCY];
  logic [31:0] cnt_q, cnt_d;
  logic stall, acc, err;
  logic [DATA_W-1:0] rd;
  assign stall     = rsp_valid & ~rsp_ready;
  assign req_ready = ~stall & ~flush & ~rst;
  assign acc       = req_valid & req_ready;
  assign err       = (req_addr[1:0] != 2'b0) | (req_addr[31:ADDR_W+2] != '0);
  // combinational read sampled into stage 0 gives read-before-write on a same-edge preload
  assign rd        = err ? '0 : mem[req_addr[ADDR_W+1:2]];
  assign rsp_valid = v_q[LATENCY-1];
  assign rsp_err   = e_q[LATENCY-1];
  assign rsp_data  = d_q[LATENCY-1];
  assign rsp_addr  = a_q[LATENCY-1];
  assign fetch_cnt = cnt_q;
  always_comb begin
    v_d = v_q;
    e_d = e_q;
    d_d = d_q;
    a_d = a_q;
    cnt_d = cnt_q + {31'b0, rsp_valid & rsp_ready};
    if (!stall) begin
      for (int i = LATENCY - 1; i > 0; i--) begin
        v_d[i] = v_q[i-1];
        e_d[i] = e_q[i-1];
        d_d[i] = d_q[i-1];
        a_d[i] = a_q[i-1];
      end
      v_d[0] = acc;
      e_d[0] = err;
      d_d[0] = rd;
      a_d[0] = req_addr;
    end
    if (flush) v_d = '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q   <= '0;
      e_q   <= '0;
      cnt_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        d_q[i] <= '0;
        a_q[i] <= '0;
      end
    end else begin
      v_q   <= v_d;
      e_q   <= e_d;
      d_q   <= d_d;
      a_q   <= a_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem[wr_addr] <= wr_data;
  end
`ifdef IMEM_TRACE_EN
  always @(posedge clk) begin
    if (!rst && rsp_valid && rsp_ready)
      $display("imaddr=%8X imdout=%8X err=%0d", rsp_addr, rsp_data, rsp_err);
  end
`else
`endif
endmodule
